// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM read/write port between two requesters.
// Port 0 carries training/input fetches, port 1 the inferred-type write-back.
// Round-robin arbitration with one fixed-latency transfer in flight at a time.
// All outputs are registered.
module sdram_arbiter #(
  parameter int unsigned W      = 16,
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned RD_LAT = 4,
  parameter int unsigned WR_LAT = 10
) (
  input  logic              clk,
  input  logic              rst,
  // Requester 0
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [W-1:0]      wdata0,
  output logic              ack0,
  // Requester 1
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [W-1:0]      wdata1,
  output logic              ack1,
  // Shared status and read result
  output logic [W-1:0]      rdata,
  output logic              busy,
  // SDRAM side
  output logic              read,
  output logic [ADDR_W-1:0] readaddress,
  input  logic [W-1:0]      readdata,
  output logic              write,
  output logic [ADDR_W-1:0] writeaddress,
  output logic [W-1:0]      writedata
);

  localparam int unsigned MaxLat = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  // One spare bit so the counter can reach MaxLat without wrapping.
  localparam int unsigned CntW   = $clog2(MaxLat) + 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdWait = 2'd1,
    StWrWait = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              busy_q, busy_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [W-1:0]      rdata_q, rdata_d;
  logic [ADDR_W-1:0] readaddress_q, readaddress_d;
  logic [ADDR_W-1:0] writeaddress_q, writeaddress_d;
  logic [W-1:0]      writedata_q, writedata_d;

  logic grant;
  logic win;
  logic win_we;
  logic rd_done;
  logic win_addr_sel;
  logic rd_cnt_hit;
  logic wr_cnt_hit;

  // Arbitration decision and latency terminal counts
  always_comb begin
    // No grant in the ack cycle: this forces a one-cycle gap between transfers.
    grant = (state_q == StIdle) && !ack0_q && !ack1_q && (req0 || req1);
    // On a tie the port that did not win last time goes first.
    if (req0 && req1) begin
      win = ~last_q;
    end else begin
      win = req1;
    end
    win_we       = win ? we1 : we0;
    win_addr_sel = win;
    rd_cnt_hit   = (cnt_q == CntW'(RD_LAT - 1));
    wr_cnt_hit   = (cnt_q == CntW'(WR_LAT - 1));
    rd_done      = (state_q == StRdWait) && rd_cnt_hit;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = win_we ? StWrWait : StRdWait;
        end
      end
      StRdWait: begin
        if (rd_cnt_hit) begin
          state_d = StIdle;
        end
      end
      StWrWait: begin
        if (wr_cnt_hit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs, counter and round-robin pointer
  always_comb begin
    ack0_d         = 1'b0;
    ack1_d         = 1'b0;
    read_d         = 1'b0;
    write_d        = 1'b0;
    busy_d         = busy_q;
    cnt_d          = cnt_q;
    last_d         = last_q;
    rdata_d        = rdata_q;
    readaddress_d  = readaddress_q;
    writeaddress_d = writeaddress_q;
    writedata_d    = writedata_q;
    unique case (state_q)
      StIdle: begin
        // Clears busy the edge after the ack cycle.
        busy_d = 1'b0;
        if (grant) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          last_d = win;
          if (win_we) begin
            write_d        = 1'b1;
            writeaddress_d = win_addr_sel ? addr1 : addr0;
            writedata_d    = win_addr_sel ? wdata1 : wdata0;
          end else begin
            read_d        = 1'b1;
            readaddress_d = win_addr_sel ? addr1 : addr0;
          end
        end
      end
      StRdWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (rd_done) begin
          rdata_d = readdata;
          ack0_d  = ~last_q;
          ack1_d  = last_q;
        end
      end
      StWrWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (wr_cnt_hit) begin
          ack0_d = ~last_q;
          ack1_d = last_q;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Output and datapath registers; reset abandons any transfer in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      last_q         <= 1'b1;
      ack0_q         <= 1'b0;
      ack1_q         <= 1'b0;
      busy_q         <= 1'b0;
      read_q         <= 1'b0;
      write_q        <= 1'b0;
      rdata_q        <= '0;
      readaddress_q  <= '0;
      writeaddress_q <= '0;
      writedata_q    <= '0;
    end else begin
      cnt_q          <= cnt_d;
      last_q         <= last_d;
      ack0_q         <= ack0_d;
      ack1_q         <= ack1_d;
      busy_q         <= busy_d;
      read_q         <= read_d;
      write_q        <= write_d;
      rdata_q        <= rdata_d;
      readaddress_q  <= readaddress_d;
      writeaddress_q <= writeaddress_d;
      writedata_q    <= writedata_d;
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign busy         = busy_q;
  assign read         = read_q;
  assign write        = write_q;
  assign rdata        = rdata_q;
  assign readaddress  = readaddress_q;
  assign writeaddress = writeaddress_q;
  assign writedata    = writedata_q;

  // Protocol invariants
  a_ack_exclusive: assert property (@(posedge clk) disable iff (rst) !(ack0_q && ack1_q));
  a_rw_exclusive:  assert property (@(posedge clk) disable iff (rst) !(read_q && write_q));
  a_read_single:   assert property (@(posedge clk) disable iff (rst) read_q |=> !read_q);
  a_write_single:  assert property (@(posedge clk) disable iff (rst) write_q |=> !write_q);

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench for sdram_arbiter with a fixed-latency SDRAM model.
module tb_sdram_arbiter;

  localparam int unsigned W      = 16;
  localparam int unsigned ADDR_W = 25;
  localparam int unsigned RD_LAT = 4;
  localparam int unsigned WR_LAT = 10;

  logic              clk;
  logic              rst;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [W-1:0]      wdata0, wdata1;
  logic              ack0, ack1, busy, read, write;
  logic [W-1:0]      rdata, readdata, writedata;
  logic [ADDR_W-1:0] readaddress, writeaddress;

  sdram_arbiter #(
    .W      (W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT),
    .WR_LAT (WR_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .we0          (we0),
    .addr0        (addr0),
    .wdata0       (wdata0),
    .ack0         (ack0),
    .req1         (req1),
    .we1          (we1),
    .addr1        (addr1),
    .wdata1       (wdata1),
    .ack1         (ack1),
    .rdata        (rdata),
    .busy         (busy),
    .read         (read),
    .readaddress  (readaddress),
    .readdata     (readdata),
    .write        (write),
    .writeaddress (writeaddress),
    .writedata    (writedata)
  );

  // Expected transfer, in expected grant order
  typedef struct {
    int                port;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [W-1:0]      data;  // write data, or expected read result
    bit                b2b;   // issued exactly two cycles after the previous ack
  } txn_t;

  // Pending request for a requester; hold != 0 withdraws after that many cycles
  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [W-1:0]      wdata;
    int                hold;
  } req_t;

  txn_t sb[$];
  req_t pq[2][$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int n_ack0, n_ack1, n_wr;

  logic              req_r   [2];
  logic              we_r    [2];
  logic [ADDR_W-1:0] addr_r  [2];
  logic [W-1:0]      wdata_r [2];

  assign req0   = req_r[0];
  assign req1   = req_r[1];
  assign we0    = we_r[0];
  assign we1    = we_r[1];
  assign addr0  = addr_r[0];
  assign addr1  = addr_r[1];
  assign wdata0 = wdata_r[0];
  assign wdata1 = wdata_r[1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] init_val(input int i);
    return 16'(i * 37 + 11);
  endfunction

  task automatic issue(input int port, input bit we, input logic [ADDR_W-1:0] addr,
                       input logic [W-1:0] data, input bit b2b);
    txn_t t;
    req_t r;
    t.port = port; t.we = we; t.addr = addr; t.data = data; t.b2b = b2b;
    r.we = we; r.addr = addr; r.wdata = data; r.hold = 0;
    sb.push_back(t);
    pq[port].push_back(r);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_ack0"}, 32'(ack0), 0);
    check_eq({tag, "_ack1"}, 32'(ack1), 0);
    check_eq({tag, "_read"}, 32'(read), 0);
    check_eq({tag, "_write"}, 32'(write), 0);
    check_eq({tag, "_rdata"}, 32'(rdata), 0);
    check_eq({tag, "_raddr"}, 32'(readaddress), 0);
    check_eq({tag, "_waddr"}, 32'(writeaddress), 0);
    check_eq({tag, "_wdata"}, 32'(writedata), 0);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && pq[0].size() == 0 && pq[1].size() == 0 && !busy) done = 1'b1;
    end
    check_eq({tag, "_drained"}, 32'(done), 1);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // SDRAM model: read data appears three edges after the strobe is seen
  initial begin
    logic [W-1:0] mem [1024];
    logic [W-1:0] p1, p2;
    for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
    mem[10'h040] = 16'h1234;
    p1 = 16'hDEAD;
    p2 = 16'hDEAD;
    readdata = '0;
    forever begin
      @(posedge clk);
      if (write) mem[writeaddress[9:0]] <= writedata;
      p1       <= read ? mem[readaddress[9:0]] : 16'hDEAD;
      p2       <= p1;
      readdata <= p2;
    end
  end

  // Requesters: hold req until ack (or withdrawal), re-request at once if more queued
  initial begin
    int held [2];
    bit a;
    req_t h;
    for (int p = 0; p < 2; p++) begin
      req_r[p] = 1'b0; we_r[p] = 1'b0; addr_r[p] = '0; wdata_r[p] = '0; held[p] = 0;
    end
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        a = (p == 0) ? ack0 : ack1;
        if (req_r[p]) begin
          held[p]++;
          if (pq[p].size() != 0) begin
            h = pq[p][0];
            if (a || (h.hold != 0 && held[p] >= h.hold)) begin
              void'(pq[p].pop_front());
              req_r[p] = 1'b0;
            end
          end
        end
        if (pq[p].size() != 0) begin
          if (!req_r[p]) held[p] = 0;
          h          = pq[p][0];
          req_r[p]   = 1'b1;
          we_r[p]    = h.we;
          addr_r[p]  = h.addr;
          wdata_r[p] = h.wdata;
        end else begin
          req_r[p] = 1'b0;
        end
      end
    end
  end

  // Monitor: checks strobes and acks against the scoreboard head
  initial begin
    bit   prev_rd, prev_wr, prev_ack, head_issued;
    int   issue_cyc, last_ack_cyc;
    logic [W-1:0] exp_rdata;
    txn_t t;
    prev_rd = 0; prev_wr = 0; prev_ack = 0; head_issued = 0;
    issue_cyc = 0; last_ack_cyc = 0; exp_rdata = '0;
    n_ack0 = 0; n_ack1 = 0; n_wr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rd = 0; prev_wr = 0; prev_ack = 0; head_issued = 0; exp_rdata = '0;
      end else begin
        check_eq("ack_exclusive", 32'(ack0 & ack1), 0);
        check_eq("rw_exclusive", 32'(read & write), 0);
        if (prev_rd || prev_wr) check_eq("strobe_width", 32'(read | write), 0);
        if (prev_ack) begin
          check_eq("ack_width", 32'(ack0 | ack1), 0);
          check_eq("busy_after_ack", 32'(busy), 0);
        end
        if (write) n_wr++;
        if (read || write) begin
          if (sb.size() == 0 || head_issued) begin
            check_eq("spurious_issue", 32'(read | write), 0);
          end else begin
            t = sb[0];
            head_issued = 1;
            issue_cyc = cyc;
            check_eq("issue_we", 32'(write), 32'(t.we));
            check_eq("issue_busy", 32'(busy), 1);
            if (t.we) begin
              check_eq("issue_waddr", 32'(writeaddress), 32'(t.addr));
              check_eq("issue_wdata", 32'(writedata), 32'(t.data));
            end else begin
              check_eq("issue_raddr", 32'(readaddress), 32'(t.addr));
            end
            if (t.b2b) check_eq("issue_gap", 32'(cyc - last_ack_cyc), 2);
          end
        end
        if (ack0 || ack1) begin
          if (ack1) n_ack1++;
          else n_ack0++;
          if (sb.size() == 0 || !head_issued) begin
            check_eq("spurious_ack", 32'(ack0 | ack1), 0);
          end else begin
            t = sb.pop_front();
            head_issued = 0;
            check_eq("ack_port", 32'(ack1), 32'(t.port));
            check_eq("ack_latency", 32'(cyc - issue_cyc), t.we ? WR_LAT : RD_LAT);
            check_eq("ack_busy", 32'(busy), 1);
            if (!t.we) exp_rdata = t.data;
            check_eq("ack_rdata", 32'(rdata), 32'(exp_rdata));
          end
          last_ack_cyc = cyc;
        end
        prev_rd  = read;
        prev_wr  = write;
        prev_ack = ack0 | ack1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // Main sequence
  initial begin
    int  a0, a1, w0;
    bit  seen;
    req_t r;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // 1: reset while a write is in flight, then a normal read
    issue(1, 1'b1, 25'h200, 16'hBEEF, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (write) seen = 1'b1;
    end
    check_eq("t1_write_issued", 32'(seen), 1);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("t1_async");
    pq[0].delete();
    pq[1].delete();
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    a0 = n_ack0; a1 = n_ack1;
    repeat (20) @(negedge clk);
    check_eq("t1_no_ack", 32'((n_ack0 - a0) + (n_ack1 - a1)), 0);
    check_eq("t1_idle_busy", 32'(busy), 0);
    issue(0, 1'b0, 25'h200, 16'hBEEF, 1'b0);
    wait_drain("t1", 100);

    // 2: single read
    issue(0, 1'b0, 25'h040, 16'h1234, 1'b0);
    wait_drain("t2", 100);

    // 3: single write, then read it back on the same port
    issue(1, 1'b1, 25'h100, 16'h0005, 1'b0);
    wait_drain("t3w", 100);
    issue(1, 1'b0, 25'h100, 16'h0005, 1'b0);
    wait_drain("t3r", 100);

    // 4: both ports requesting from reset release; expect 0,1,0,1
    @(negedge clk);
    rst = 1'b1;
    issue(0, 1'b0, 25'h040, 16'h1234, 1'b0);
    issue(1, 1'b1, 25'h300, 16'h00AA, 1'b1);
    issue(0, 1'b0, 25'h300, 16'h00AA, 1'b1);
    issue(1, 1'b0, 25'h100, 16'h0005, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_drain("t4", 200);

    // 5: port 0 re-requests on every ack while port 1 waits; expect 0,1,0,0
    issue(0, 1'b0, 25'h010, init_val(32'h010), 1'b0);
    issue(1, 1'b1, 25'h3FF, 16'h7777, 1'b1);
    issue(0, 1'b0, 25'h020, init_val(32'h020), 1'b1);
    issue(0, 1'b0, 25'h3FF, 16'h7777, 1'b1);
    wait_drain("t5", 200);

    // 6: port 1 pulses a request for one cycle while port 0 is busy
    a1 = n_ack1; w0 = n_wr;
    issue(0, 1'b0, 25'h040, 16'h1234, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check_eq("t6_busy_seen", 32'(seen), 1);
    @(posedge clk);
    #2;
    r.we = 1'b1; r.addr = 25'h050; r.wdata = 16'h1111; r.hold = 1;
    pq[1].push_back(r);
    wait_drain("t6", 100);
    repeat (15) @(negedge clk);
    check_eq("t6_no_ack1", 32'(n_ack1 - a1), 0);
    check_eq("t6_no_write", 32'(n_wr - w0), 0);
    check_eq("t6_busy_low", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
